// File: rtl/poly_synth_pkg.sv
// Shared types, sizes and Q11.20 arithmetic helpers for the polyphonic sawtooth synth.
// The helpers are also used by the bench to build note ratios.
package poly_synth_pkg;

    localparam int NUM_VOICES = 8;
    localparam int FRAC_BITS  = 20;

    typedef logic signed [31:0] q20_t;

    function automatic q20_t q20_mul(input q20_t a, input q20_t b);
        logic signed [63:0] prod;
        prod = 64'(a) * 64'(b);
        return 32'(prod >>> FRAC_BITS);
    endfunction

    // Divide by zero yields zero rather than an undefined quotient.
    function automatic q20_t q20_div(input q20_t a, input q20_t b);
        logic signed [63:0] num;
        logic signed [63:0] quo;
        num = 64'(a) <<< FRAC_BITS;
        if (b == 32'sd0) begin
            quo = 64'sd0;
        end else begin
            quo = num / 64'(b);
        end
        return 32'(quo);
    endfunction

endpackage

// File: rtl/poly_synth_if.sv
// Control/audio bundle between the note logic (master) and the synth (slave).
interface poly_synth_if;
    import poly_synth_pkg::*;

    logic [31:0]                 clock_speed;
    logic [2:0]                  cutoff;
    q20_t [NUM_VOICES-1:0]       voice_volumes;
    q20_t [NUM_VOICES-1:0]       frequencies;
    logic signed [15:0]          synth_out;

    modport master (output clock_speed, output cutoff, output voice_volumes,
                    output frequencies, input synth_out);
    modport slave  (input clock_speed, input cutoff, input voice_volumes,
                    input frequencies, output synth_out);
endinterface

// File: rtl/poly_synth_voice.sv
// One sawtooth oscillator: pitch-to-increment divide, phase accumulator,
// saw extraction and saturating volume scaling.
module synth_voice
    import poly_synth_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        clock_speed_i,
    input  q20_t               freq_i,
    input  q20_t               vol_i,
    output logic signed [15:0] sample_o
);

    logic [31:0]        phase_q;
    logic [31:0]        phase_d;
    logic [31:0]        inc_s;
    logic [43:0]        num_s;
    logic [43:0]        den_s;
    logic signed [15:0] saw_s;
    logic signed [47:0] saw_ext_s;
    logic signed [47:0] vol_ext_s;
    logic signed [47:0] prod_s;
    logic signed [47:0] scaled_s;

    // Phase increment = freq * 2^32 / fs; negative pitch or zero rate stalls the voice
    always_comb begin
        num_s = 44'd0;
        den_s = {12'd0, clock_speed_i};
        inc_s = 32'd0;
        if (!freq_i[31]) begin
            num_s = {freq_i, 12'd0};
        end else begin
            num_s = 44'd0;
        end
        if (clock_speed_i != 32'd0) begin
            inc_s = 32'(num_s / den_s);
        end else begin
            inc_s = 32'd0;
        end
        phase_d = phase_q + inc_s;
    end

    // Phase accumulator, wraps modulo 2^32
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= 32'd0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Saw scaled by volume, clamped to 16-bit audio range
    always_comb begin
        saw_s     = signed'(phase_q[31:16]);
        saw_ext_s = 48'(saw_s);
        vol_ext_s = 48'(vol_i);
        prod_s    = saw_ext_s * vol_ext_s;
        scaled_s  = prod_s >>> FRAC_BITS;
        if (scaled_s > 48'sd32767) begin
            sample_o = 16'sh7FFF;
        end else if (scaled_s < -48'sd32768) begin
            sample_o = 16'sh8000;
        end else begin
            sample_o = scaled_s[15:0];
        end
    end

endmodule

// File: rtl/poly_synth.sv
// 8-voice sawtooth synth top: voice bank, 1/8 mixer and one-pole low-pass
// filter whose state is the registered audio output.
module poly_synth
    import poly_synth_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    poly_synth_if.slave  bus
);

    logic signed [15:0] voice_sample_s [NUM_VOICES];
    logic signed [18:0] mix_sum_s;
    logic signed [15:0] mix_s;
    logic signed [16:0] diff_s;
    logic signed [16:0] step_s;
    logic signed [15:0] f_q;
    logic signed [15:0] f_d;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        synth_voice u_voice (
            .clk           (clk),
            .reset_n       (reset_n),
            .clock_speed_i (bus.clock_speed),
            .freq_i        (bus.frequencies[g]),
            .vol_i         (bus.voice_volumes[g]),
            .sample_o      (voice_sample_s[g])
        );
    end

    // Mix of eight 16-bit voices fits 19 bits; dividing by 8 cannot clip
    always_comb begin
        mix_sum_s = 19'sd0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            mix_sum_s = mix_sum_s + 19'(voice_sample_s[v]);
        end
        mix_s  = 16'(mix_sum_s >>> 3);
        diff_s = 17'(mix_s) - 17'(f_q);
        step_s = diff_s >>> bus.cutoff;
        f_d    = 16'(17'(f_q) + step_s);
    end

    // Filter state doubles as the output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_q <= 16'sd0;
        end else begin
            f_q <= f_d;
        end
    end

    assign bus.synth_out = f_q;

endmodule

// File: tb/tb_poly_synth.sv
// Directed-vector bench for poly_synth: reset, helper arithmetic, single/multi
// voice waveforms, filter, silence cases and mixer saturation.
module tb_poly_synth;
    import poly_synth_pkg::*;

    // 12 kHz does not fit Q11.20, so quarter/half-rate ratios use fs = 400 Hz.
    localparam q20_t ONE   = 32'sd1048576;
    localparam q20_t F100  = 32'sd104857600;
    localparam q20_t F200  = 32'sd209715200;
    localparam q20_t F1000 = 32'sd1048576000;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;

    poly_synth_if bus ();

    poly_synth dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [31:0] fs, input logic [2:0] cut);
        bus.clock_speed   = fs;
        bus.cutoff        = cut;
        bus.frequencies   = '0;
        bus.voice_volumes = '0;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        setup(32'd400, 3'd0);
        repeat (2) @(negedge clk);
        n_vec++;
        if (bus.synth_out !== 16'sd0) begin
            $display("FAIL reset_state: got %0d want 0", bus.synth_out);
            n_err++;
        end
    endtask

    task automatic test_functions;
        q20_t r;
        r = q20_div(32'sd3 <<< 20, 32'sd2 <<< 20);
        n_vec++;
        if (r !== 32'sd1572864) begin $display("FAIL div_3_2: got %0d want 1572864", r); n_err++; end
        r = q20_mul(32'sd110 <<< 20, 32'sd1572864);
        n_vec++;
        if (r !== 32'sd173015040) begin $display("FAIL mul_165: got %0d want 173015040", r); n_err++; end
        r = q20_div(32'sd12345, 32'sd0);
        n_vec++;
        if (r !== 32'sd0) begin $display("FAIL div_zero: got %0d want 0", r); n_err++; end
        r = q20_div(-(32'sd3 <<< 20), 32'sd2 <<< 20);
        n_vec++;
        if (r !== -32'sd1572864) begin $display("FAIL div_neg: got %0d want -1572864", r); n_err++; end
    endtask

    task automatic test_single_voice;
        int exp_a [5] = '{0, 2048, -4096, -2048, 0};
        int exp_b [4] = '{0, 256, 512, 768};
        setup(32'd400, 3'd0);
        bus.frequencies[0]   = F100;
        bus.voice_volumes[0] = ONE;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (int'(bus.synth_out) !== exp_a[i]) begin
                $display("FAIL quarter_saw edge %0d: got %0d want %0d", i + 1, bus.synth_out, exp_a[i]);
                n_err++;
            end
        end
        // 1000 Hz * 3/2 = 1500 Hz at 48 kHz steps the saw by 2048 per sample
        setup(32'd48000, 3'd0);
        bus.frequencies[0]   = q20_mul(F1000, q20_div(32'sd3 <<< 20, 32'sd2 <<< 20));
        bus.voice_volumes[0] = ONE;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (int'(bus.synth_out) !== exp_b[i]) begin
                $display("FAIL ratio_saw edge %0d: got %0d want %0d", i + 1, bus.synth_out, exp_b[i]);
                n_err++;
            end
        end
    endtask

    task automatic test_cutoff;
        int exp_c [4] = '{0, -2048, -1024, -2560};
        setup(32'd400, 3'd1);
        bus.frequencies[0]   = F200;
        bus.voice_volumes[0] = ONE;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (int'(bus.synth_out) !== exp_c[i]) begin
                $display("FAIL cutoff1 edge %0d: got %0d want %0d", i + 1, bus.synth_out, exp_c[i]);
                n_err++;
            end
        end
    endtask

    task automatic test_mix_and_invert;
        int exp_m [4] = '{0, 0, -4096, -4096};
        int exp_n [5] = '{0, -2048, 4095, 2048, 0};
        setup(32'd400, 3'd0);
        bus.frequencies[0]   = F100;
        bus.voice_volumes[0] = ONE;
        bus.frequencies[1]   = F200;
        bus.voice_volumes[1] = ONE >>> 1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (int'(bus.synth_out) !== exp_m[i]) begin
                $display("FAIL two_voice edge %0d: got %0d want %0d", i + 1, bus.synth_out, exp_m[i]);
                n_err++;
            end
        end
        setup(32'd400, 3'd0);
        bus.frequencies[0]   = F100;
        bus.voice_volumes[0] = -ONE;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (int'(bus.synth_out) !== exp_n[i]) begin
                $display("FAIL invert edge %0d: got %0d want %0d", i + 1, bus.synth_out, exp_n[i]);
                n_err++;
            end
        end
    endtask

    task automatic test_reset_midstream;
        setup(32'd400, 3'd0);
        bus.frequencies[0]   = F100;
        bus.voice_volumes[0] = ONE;
        do_reset();
        tick();
        tick();
        n_vec++;
        if (bus.synth_out !== 16'sd2048) begin $display("FAIL pre_reset: got %0d want 2048", bus.synth_out); n_err++; end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (bus.synth_out !== 16'sd0) begin $display("FAIL async_clear: got %0d want 0", bus.synth_out); n_err++; end
        tick();
        n_vec++;
        if (bus.synth_out !== 16'sd0) begin $display("FAIL reset_held: got %0d want 0", bus.synth_out); n_err++; end
        reset_n = 1'b1;
        tick();
        n_vec++;
        if (bus.synth_out !== 16'sd0) begin $display("FAIL restart_e1: got %0d want 0", bus.synth_out); n_err++; end
        tick();
        n_vec++;
        if (bus.synth_out !== 16'sd2048) begin $display("FAIL restart_e2: got %0d want 2048", bus.synth_out); n_err++; end
    endtask

    task automatic test_silence;
        for (int s = 0; s < 3; s++) begin
            setup((s == 1) ? 32'd0 : 32'd400, 3'd0);
            for (int v = 0; v < NUM_VOICES; v++) begin
                bus.frequencies[v]   = (s == 2) ? -F100 : F100;
                bus.voice_volumes[v] = (s == 0) ? 32'sd0 : ONE;
            end
            bus.frequencies[7] = (s == 2) ? 32'sd0 : F100;
            do_reset();
            for (int i = 0; i < 100; i++) begin
                tick();
                n_vec++;
                if (bus.synth_out !== 16'sd0) begin
                    $display("FAIL silence case %0d edge %0d: got %0d want 0", s, i + 1, bus.synth_out);
                    n_err++;
                end
            end
        end
    endtask

    task automatic test_saturation;
        int exp_s [5] = '{0, 32767, -32768, -32768, 0};
        setup(32'd400, 3'd0);
        for (int v = 0; v < NUM_VOICES; v++) begin
            bus.frequencies[v]   = F100;
            bus.voice_volumes[v] = ONE <<< 1;
        end
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (int'(bus.synth_out) !== exp_s[i]) begin
                $display("FAIL saturate edge %0d: got %0d want %0d", i + 1, bus.synth_out, exp_s[i]);
                n_err++;
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_functions();
        test_single_voice();
        test_cutoff();
        test_mix_and_invert();
        test_reset_midstream();
        test_silence();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
